// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state type and source select constants for arb_2x1_rr.
package arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, LOCK_A = 2'd1, LOCK_B = 2'd2} state_t;
   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/rr_grant2.sv
// rr_grant2: combinational two-way round-robin grant; prio names the favoured source on contention.
module rr_grant2 (
   input  logic [1:0] valid,
   input  logic       prio,
   output logic [1:0] grant
);
   assign grant[0] = valid[0] & (!valid[1] | !prio);
   assign grant[1] = valid[1] & (!valid[0] | prio);
endmodule

// File: rtl/arb_2x1_rr.sv
// arb_2x1_rr: two-input round-robin valid/ready arbiter with registered output beat and select.
// Define ARB_2X1_LOCK_EN to hold the grant for a whole packet using a_last/b_last.
module arb_2x1_rr
   import arb_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         a_valid,
   input  logic [W-1:0] a_data,
   output logic         a_ready,
   input  logic         b_valid,
   input  logic [W-1:0] b_data,
   output logic         b_ready,
`ifdef ARB_2X1_LOCK_EN
   input  logic         a_last,
   input  logic         b_last,
`endif
   output logic         y_valid,
   output logic [W-1:0] y_data,
   output logic         y_src,
   input  logic         y_ready
);
   logic       load;
   logic       prio;
   logic       rotate;
   logic [1:0] req;
   logic [1:0] grant;

   assign load = !y_valid | y_ready;

`ifdef ARB_2X1_LOCK_EN
   state_t state, state_nx;
   // A locked packet masks the other source out of arbitration entirely
   assign req    = {b_valid & (state != LOCK_A), a_valid & (state != LOCK_B)};
   assign rotate = (a_ready & a_last) | (b_ready & b_last);
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (a_ready) state_nx = a_last ? IDLE : LOCK_A;
      else if (b_ready) state_nx = b_last ? IDLE : LOCK_B;
   end
`else
   assign req    = {b_valid, a_valid};
   assign rotate = a_ready | b_ready;
`endif

   rr_grant2 u_grant (.valid(req), .prio(prio), .grant(grant));

   assign a_ready = rst_n & load & grant[0];
   assign b_ready = rst_n & load & grant[1];

   always_ff @(posedge clk)
      if (!rst_n) begin
         y_valid <= 1'b0;
         y_data  <= '0;
         y_src   <= SRC_A;
         prio    <= 1'b0;
      end else if (load) begin
         y_valid <= a_ready | b_ready;
         if (a_ready | b_ready) begin
            y_data <= b_ready ? b_data : a_data;
            y_src  <= b_ready ? SRC_B : SRC_A;
         end
         if (rotate) prio <= a_ready;
      end
endmodule
